// File: rtl/uart_sender.sv
// UART 8N1 transmitter draining a word-wide read FIFO.
// Each word is sent most-significant byte first, each byte LSB first.
module uart_sender #(
  parameter int unsigned UART_BPS      = 9600,
  parameter int unsigned CLK_FREQ      = 50_000_000,
  parameter int unsigned FIFO_RD_WIDTH = 16,
  parameter int unsigned FIFO_RD_BYTE  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     fifo_empty,
  input  logic [FIFO_RD_WIDTH-1:0] fifo_rd_data,
  output logic                     fifo_rd_en,
  output logic                     tx,
  output logic                     busy
);

  localparam int unsigned BAUD_MAX = CLK_FREQ / UART_BPS;
  localparam int unsigned BAUD_W   = (BAUD_MAX > 1) ? $clog2(BAUD_MAX) : 1;
  localparam int unsigned BYTE_W   = (FIFO_RD_BYTE > 1) ? $clog2(FIFO_RD_BYTE) : 1;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LATCH,
    START,
    DATA,
    STOP
  } state_t;

  state_t                   state;
  logic [1:0]               rst_sync;
  logic                     rst_int;
  logic [FIFO_RD_WIDTH-1:0] shreg;
  logic [BYTE_W-1:0]        byte_cnt;
  logic [BAUD_W-1:0]        baud_cnt;
  logic [2:0]               bit_cnt;
  logic [7:0]               cur_byte;
  logic                     baud_last;

  // Asynchronous assertion, synchronous release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_int = rst_sync[1];

  assign cur_byte  = shreg[FIFO_RD_WIDTH-1 -: 8];
  assign baud_last = (baud_cnt == BAUD_W'(BAUD_MAX - 1));

  always_ff @(posedge clk or negedge rst_int) begin
    if (!rst_int) begin
      state      <= IDLE;
      tx         <= 1'b1;
      fifo_rd_en <= 1'b0;
      busy       <= 1'b0;
      shreg      <= '0;
      byte_cnt   <= '0;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
    end else begin
      fifo_rd_en <= 1'b0;
      case (state)
        IDLE: begin
          tx   <= 1'b1;
          busy <= 1'b0;
          if (!fifo_empty) begin
            state      <= READ;
            fifo_rd_en <= 1'b1;
            busy       <= 1'b1;
          end
        end
        // Start bit is driven from LATCH on so the word gap is only IDLE+READ.
        READ: begin
          state <= LATCH;
          tx    <= 1'b0;
        end
        LATCH: begin
          shreg    <= fifo_rd_data;
          byte_cnt <= '0;
          baud_cnt <= BAUD_W'(1);
          state    <= START;
        end
        START: begin
          if (baud_last) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= cur_byte[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        DATA: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              tx      <= cur_byte[bit_cnt + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        STOP: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (byte_cnt < BYTE_W'(FIFO_RD_BYTE - 1)) begin
              shreg    <= shreg << 8;
              byte_cnt <= byte_cnt + BYTE_W'(1);
              tx       <= 1'b0;
              state    <= START;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        default: begin
          tx    <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_sender.sv
// Bench for uart_sender: FIFO model feeding random words, a line-level
// 8N1 decoder checking every tx cycle, plus literal frame/reset checks.
module tb_uart_sender;

  localparam int unsigned CLK_FREQ = 50_000_000;
  localparam int unsigned UART_BPS = 5_000_000;
  localparam int unsigned BAUD     = CLK_FREQ / UART_BPS;
  localparam int unsigned W        = 16;
  localparam int unsigned NB       = 2;
  localparam int unsigned FRAME    = 10 * BAUD;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         fifo_empty = 1'b1;
  logic [W-1:0] fifo_rd_data = '0;
  logic         fifo_rd_en;
  logic         tx;
  logic         busy;

  uart_sender #(
    .UART_BPS(UART_BPS),
    .CLK_FREQ(CLK_FREQ),
    .FIFO_RD_WIDTH(W),
    .FIFO_RD_BYTE(NB)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .fifo_empty(fifo_empty),
    .fifo_rd_data(fifo_rd_data),
    .fifo_rd_en(fifo_rd_en),
    .tx(tx),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [W-1:0] fq[$];     // words waiting in the FIFO
  logic [9:0]   exp_q[$];  // {first_of_word, last_of_word, byte} owed on the line
  logic         cap[$];

  bit       in_frame = 0, expect_start = 0, toggle_en = 0, gap_chk = 0;
  bit       have_prev = 0, log_en = 0, cur_first = 0, cur_last = 0;
  logic     prev_rd = 1'b0;
  logic [7:0] cur = '0;
  int       pos = 0, cyc = 0, end_cyc = 0, bytes_done = 0, rd_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: FIFO service, per-cycle output checks, fifo_empty drive.
  task automatic tick();
    int   bitn;
    logic e;
    @(negedge clk);
    cyc++;
    chk("busy", 32'(busy), 32'(fifo_rd_en === 1'b1 || exp_q.size() != 0 || in_frame));
    if (fifo_rd_en === 1'b1) begin
      rd_cnt++;
      chk("rd_en_single", 32'(prev_rd), 0);
      chk("rd_en_nonempty", 32'(fq.size() != 0), 1);
      if (fq.size() != 0) begin
        fifo_rd_data = fq.pop_front();
        for (int k = 0; k < NB; k++)
          exp_q.push_back({k == 0, k == NB - 1, 8'(fifo_rd_data >> (8 * (NB - 1 - k)))});
      end
    end
    prev_rd = fifo_rd_en;

    if (expect_start) begin
      chk("no_intra_gap", 32'(tx), 0);
      expect_start = 0;
    end
    if (!in_frame) begin
      if (tx === 1'b0) begin
        chk("start_has_byte", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) {cur_first, cur_last, cur} = exp_q.pop_front();
        else {cur_first, cur_last, cur} = 10'h3FF;
        if (gap_chk && have_prev && cur_first) chk("word_gap", 32'(cyc - end_cyc), 3);
        in_frame = 1;
        pos = 0;
      end else begin
        chk("tx_idle", 32'(tx), 1);
      end
    end
    if (in_frame) begin
      bitn = pos / BAUD;
      e = (bitn == 0) ? 1'b0 : (bitn == 9) ? 1'b1 : cur[bitn-1];
      chk("tx_bit", 32'(tx), 32'(e));
      if (log_en) cap.push_back(tx);
      pos++;
      if (pos == FRAME) begin
        in_frame = 0;
        end_cyc = cyc;
        have_prev = 1;
        bytes_done++;
        if (!cur_last) expect_start = 1;
      end
    end
    fifo_empty = (toggle_en && busy) ? 1'($urandom_range(0, 1)) : (fq.size() == 0);
  endtask

  task automatic push(input logic [W-1:0] w);
    fq.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((fq.size() != 0 || exp_q.size() != 0 || in_frame || busy !== 1'b0) && n < budget) begin
      tick();
      n++;
    end
    chk("idle_within_budget", 32'(n < budget), 1);
    repeat (5) tick();
  endtask

  // Reset in the middle of a frame of word w, when the frame position reaches at_pos.
  task automatic mid_reset(input logic [W-1:0] w, input int at_pos);
    int n = 0;
    int rd0;
    push(w);
    while (!(in_frame && pos == at_pos) && n < 1000) begin
      tick();
      n++;
    end
    chk("reached_frame_pos", 32'(n < 1000), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_tx", 32'(tx), 1);
    chk("rst_async_busy", 32'(busy), 0);
    chk("rst_async_rd_en", 32'(fifo_rd_en), 0);
    in_frame = 0;
    expect_start = 0;
    exp_q.delete();
    prev_rd = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    rd0 = rd_cnt;
    repeat (300) tick();
    chk("no_read_after_reset", 32'(rd_cnt), 32'(rd0));
  endtask

  initial begin
    logic [0:19] lit;
    int b0;

    // Reset state and quiet idle with an empty FIFO.
    #1 rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_tx", 32'(tx), 1);
    chk("rst_rd_en", 32'(fifo_rd_en), 0);
    chk("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    repeat (1000) tick();
    chk("idle_no_rd_en", 32'(rd_cnt), 0);
    chk("idle_tx_high", 32'(tx), 1);

    // Single word with literal frame expectations.
    rd_cnt = 0;
    log_en = 1;
    push(16'hA55A);
    wait_idle(1000);
    log_en = 0;
    chk("a55a_rd_pulses", 32'(rd_cnt), 1);
    chk("a55a_frame_cycles", 32'(cap.size()), 200);
    lit = 20'b0101001011_0010110101;
    if (cap.size() == 200)
      for (int i = 0; i < 200; i++) chk("a55a_literal", 32'(cap[i]), 32'(lit[i / 10]));

    // Two queued words: byte order and inter-word gap.
    rd_cnt = 0;
    have_prev = 0;
    gap_chk = 1;
    b0 = bytes_done;
    push(16'h1234);
    push(16'hABCD);
    wait_idle(2000);
    gap_chk = 0;
    chk("two_words_rd_pulses", 32'(rd_cnt), 2);
    chk("two_words_bytes", 32'(bytes_done - b0), 4);

    // Reset mid-frame: data bits all ones, inside a start bit, on a zero data bit.
    mid_reset(16'hFFFF, 35);
    mid_reset(16'h5AC3, 5);
    mid_reset(16'h0000, 45);

    // 64 random words preloaded: continuous stream, every word gap exact.
    rd_cnt = 0;
    have_prev = 0;
    gap_chk = 1;
    b0 = bytes_done;
    for (int i = 0; i < 64; i++) push(16'($urandom));
    wait_idle(64 * 260);
    gap_chk = 0;
    chk("stream_rd_pulses", 32'(rd_cnt), 64);
    chk("stream_bytes", 32'(bytes_done - b0), 128);

    // 64 random words at random times, fifo_empty noise while busy.
    rd_cnt = 0;
    toggle_en = 1;
    b0 = bytes_done;
    for (int i = 0; i < 64; i++) begin
      push(16'($urandom));
      repeat ($urandom_range(0, 300)) tick();
    end
    wait_idle(64 * 260);
    toggle_en = 0;
    chk("noisy_rd_pulses", 32'(rd_cnt), 64);
    chk("noisy_bytes", 32'(bytes_done - b0), 128);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
